// File: rtl/last_beat_tracker.sv
// TLAST verdict generator for the GEM rx DMA-to-AXI-Stream path: one last/not-last verdict per previous AW beat.
// Optional statistics counters are enabled with `define LASTBEAT_STATS_EN.

module last_beat_tracker_chk #(
   parameter int ADDR_WIDTH        = 12,
   parameter int BUS_WIDTH         = 32,
   parameter int OUTSTANDING_WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_full,
   input  logic                         i_beat,
   input  logic [ADDR_WIDTH-1:0]        i_addr,
   input  logic [OUTSTANDING_WIDTH:0]   i_outstanding
);
   localparam logic [ADDR_WIDTH-1:0]        ALIGN_MASK = ADDR_WIDTH'(BUS_WIDTH / 8 - 1);
   localparam logic [OUTSTANDING_WIDTH:0]   MAX_OUT    = (OUTSTANDING_WIDTH + 1)'(2 ** OUTSTANDING_WIDTH);

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_push && i_full && !i_pop));

   a_outstanding_bound: assert property (@(posedge clk) disable iff (!reset_n)
      i_outstanding <= MAX_OUT);

   a_beat_aligned: assert property (@(posedge clk) disable iff (!reset_n)
      !i_beat || ((i_addr & ALIGN_MASK) == '0));
endmodule

module last_beat_tracker #(
   parameter int ADDR_WIDTH        = 12,
   parameter int BUS_WIDTH         = 32,
   parameter int BASE_ADDR         = 0,
   parameter int NUM_BUFS          = 1,
   parameter int BUF_STRIDE        = 2048,
   parameter int OUTSTANDING_WIDTH = 2,
   parameter int OUT_FIFO_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ADDR_WIDTH-1:0]        i_addr_data,
   input  logic                         i_addr_valid,
   output logic                         i_addr_ready,
   input  logic                         i_dma_complete,
   output logic                         o_last,
   output logic                         o_last_valid,
   input  logic                         o_last_ready,
   output logic                         o_err_spurious,
   output logic                         o_err_orphan,
   output logic [OUTSTANDING_WIDTH:0]   o_outstanding,
   output logic [15:0]                  o_stat_pkts,
   output logic [15:0]                  o_stat_spurious
);
   localparam int                CW      = OUTSTANDING_WIDTH + 1;
   localparam logic [CW-1:0]     MAX_OUT = CW'(2 ** OUTSTANDING_WIDTH);
   localparam int                PW      = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
   localparam int                FW      = PW + 1;

   logic [CW-1:0]  r_start_cnt;
   logic [CW-1:0]  r_done_cnt;
   logic [CW-1:0]  r_outstanding;
   logic           r_err_spur;
   logic           r_err_orphan;

   logic           r_last;
   logic           r_last_valid;
   logic           r_mem [OUT_FIFO_DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [FW-1:0]  r_mem_cnt;

   logic           w_beat;
   logic           w_wrap;
   logic           w_o_zero;
   logic           w_o_one;
   logic           w_push;
   logic           w_push_val;
   logic           w_start_inc;
   logic           w_done_inc;
   logic           w_spur;
   logic           w_orphan;
   logic           w_pop;
   logic           w_mem_rd;
   logic           w_mem_wr;
   logic           w_full;
   logic [FW-1:0]  w_count;
   logic [FW-1:0]  w_free;
   logic [CW-1:0]  w_start_nxt;
   logic [CW-1:0]  w_done_nxt;

   // Total occupancy includes the registered head stage; two free slots keep room for a tie-off.
   assign w_count      = r_mem_cnt + {{PW{1'b0}}, r_last_valid};
   assign w_free       = FW'(OUT_FIFO_DEPTH) - w_count;
   assign w_full       = (w_count == FW'(OUT_FIFO_DEPTH));
   assign i_addr_ready = (r_outstanding != MAX_OUT) && (w_free >= FW'(2));
   assign w_beat       = i_addr_valid && i_addr_ready;
   assign w_o_zero     = (r_outstanding == CW'(0));
   assign w_o_one      = (r_outstanding == CW'(1));
   assign w_pop        = r_last_valid && o_last_ready;
   assign w_start_nxt  = r_start_cnt + CW'(w_start_inc);
   assign w_done_nxt   = r_done_cnt + CW'(w_done_inc);

   // Ring-buffer base match: a beat at any buffer base starts a new packet.
   always_comb begin
      w_wrap = 1'b0;
      for (int k = 0; k < NUM_BUFS; k++) begin
         w_wrap = w_wrap | (i_addr_data == ADDR_WIDTH'(BASE_ADDR + k * BUF_STRIDE));
      end
   end

   // Per-cycle event decision, completes taking priority over beats.
   always_comb begin
      w_push      = 1'b0;
      w_push_val  = 1'b0;
      w_start_inc = 1'b0;
      w_done_inc  = 1'b0;
      w_spur      = 1'b0;
      w_orphan    = 1'b0;
      if (i_dma_complete && w_o_zero) begin
         w_spur = 1'b1;
         if (w_beat) begin
            if (w_wrap) begin
               w_start_inc = 1'b1;
            end else begin
               w_orphan = 1'b1;
            end
         end else begin
            w_orphan = 1'b0;
         end
      end else if (i_dma_complete && w_o_one) begin
         w_push     = 1'b1;
         w_push_val = 1'b1;
         w_done_inc = 1'b1;
         if (w_beat) begin
            if (w_wrap) begin
               w_start_inc = 1'b1;
            end else begin
               w_orphan = 1'b1;
            end
         end else begin
            w_orphan = 1'b0;
         end
      end else if (i_dma_complete) begin
         w_done_inc = 1'b1;
         if (w_beat) begin
            w_push      = 1'b1;
            w_push_val  = w_wrap;
            w_start_inc = w_wrap;
         end else begin
            w_push = 1'b0;
         end
      end else if (w_beat) begin
         if (w_o_zero) begin
            if (w_wrap) begin
               w_start_inc = 1'b1;
            end else begin
               w_orphan = 1'b1;
            end
         end else begin
            w_push      = 1'b1;
            w_push_val  = w_wrap;
            w_start_inc = w_wrap;
         end
      end else begin
         w_push = 1'b0;
      end
   end

   // Storage behind the head register is used only when the head is occupied and not being replaced by the push.
   always_comb begin
      w_mem_rd = w_pop && (r_mem_cnt != FW'(0));
      if (w_push && r_last_valid && !(w_pop && (r_mem_cnt == FW'(0)))) begin
         w_mem_wr = !w_full || w_pop;
      end else begin
         w_mem_wr = 1'b0;
      end
   end

   // Packet counters, outstanding count and error pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_cnt   <= '0;
         r_done_cnt    <= '0;
         r_outstanding <= '0;
         r_err_spur    <= 1'b0;
         r_err_orphan  <= 1'b0;
      end else begin
         r_start_cnt   <= w_start_nxt;
         r_done_cnt    <= w_done_nxt;
         r_outstanding <= w_start_nxt - w_done_nxt;
         r_err_spur    <= w_spur;
         r_err_orphan  <= w_orphan;
      end
   end

   // Registered first-word-fall-through head stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last       <= 1'b0;
         r_last_valid <= 1'b0;
      end else if (w_pop) begin
         if (w_mem_rd) begin
            r_last <= r_mem[r_rd_ptr];
         end else if (w_push) begin
            r_last <= w_push_val;
         end else begin
            r_last       <= 1'b0;
            r_last_valid <= 1'b0;
         end
      end else if (!r_last_valid && w_push) begin
         r_last       <= w_push_val;
         r_last_valid <= 1'b1;
      end else begin
         r_last <= r_last;
      end
   end

   // Backing storage and pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
            r_mem[i] <= 1'b0;
         end
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_mem_cnt <= '0;
      end else begin
         if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= w_push_val;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_mem_rd) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         r_mem_cnt <= r_mem_cnt + FW'(w_mem_wr) - FW'(w_mem_rd);
      end
   end

   assign o_last         = r_last;
   assign o_last_valid   = r_last_valid;
   assign o_err_spurious = r_err_spur;
   assign o_err_orphan   = r_err_orphan;
   assign o_outstanding  = r_outstanding;

`ifdef LASTBEAT_STATS_EN
   logic [15:0] r_stat_pkts;
   logic [15:0] r_stat_spurious;

   // Saturating statistics: popped LAST verdicts and spurious completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stat_pkts     <= 16'h0000;
         r_stat_spurious <= 16'h0000;
      end else begin
         if (w_pop && r_last && (r_stat_pkts != 16'hFFFF)) begin
            r_stat_pkts <= r_stat_pkts + 16'h0001;
         end else begin
            r_stat_pkts <= r_stat_pkts;
         end
         if (w_spur && (r_stat_spurious != 16'hFFFF)) begin
            r_stat_spurious <= r_stat_spurious + 16'h0001;
         end else begin
            r_stat_spurious <= r_stat_spurious;
         end
      end
   end

   assign o_stat_pkts     = r_stat_pkts;
   assign o_stat_spurious = r_stat_spurious;
`else
   assign o_stat_pkts     = 16'h0000;
   assign o_stat_spurious = 16'h0000;
`endif

   last_beat_tracker_chk #(
      .ADDR_WIDTH        (ADDR_WIDTH),
      .BUS_WIDTH         (BUS_WIDTH),
      .OUTSTANDING_WIDTH (OUTSTANDING_WIDTH)
   ) u_chk (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_push        (w_push),
      .i_pop         (w_pop),
      .i_full        (w_full),
      .i_beat        (w_beat),
      .i_addr        (i_addr_data),
      .i_outstanding (r_outstanding)
   );
endmodule

// File: tb/tb_last_beat_tracker.sv
// Directed self-checking bench for last_beat_tracker (two ring buffers at 0x000 and 0x800).
module tb_last_beat_tracker;
   logic        clk;
   logic        reset_n;
   logic [11:0] i_addr_data;
   logic        i_addr_valid;
   logic        i_addr_ready;
   logic        i_dma_complete;
   logic        o_last;
   logic        o_last_valid;
   logic        o_last_ready;
   logic        o_err_spurious;
   logic        o_err_orphan;
   logic [2:0]  o_outstanding;
   logic [15:0] o_stat_pkts;
   logic [15:0] o_stat_spurious;

   int n_checks = 0;
   int n_errors = 0;

   last_beat_tracker #(
      .ADDR_WIDTH(12), .BUS_WIDTH(32), .BASE_ADDR(0), .NUM_BUFS(2),
      .BUF_STRIDE(2048), .OUTSTANDING_WIDTH(2), .OUT_FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .i_addr_data(i_addr_data), .i_addr_valid(i_addr_valid),
      .i_addr_ready(i_addr_ready), .i_dma_complete(i_dma_complete), .o_last(o_last),
      .o_last_valid(o_last_valid), .o_last_ready(o_last_ready), .o_err_spurious(o_err_spurious),
      .o_err_orphan(o_err_orphan), .o_outstanding(o_outstanding), .o_stat_pkts(o_stat_pkts),
      .o_stat_spurious(o_stat_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_verdict(input string tag, input logic exp_last);
      check({tag, "_valid"}, 32'(o_last_valid), 32'd1);
      check({tag, "_last"}, 32'(o_last), 32'(exp_last));
   endtask

   task automatic do_beat(input logic [11:0] addr);
      i_addr_valid = 1'b1;
      i_addr_data  = addr;
      tick();
      i_addr_valid = 1'b0;
   endtask

   task automatic do_complete();
      i_dma_complete = 1'b1;
      tick();
      i_dma_complete = 1'b0;
   endtask

   initial begin
      reset_n        = 1'b0;
      i_addr_data    = 12'h000;
      i_addr_valid   = 1'b0;
      i_dma_complete = 1'b0;
      o_last_ready   = 1'b1;
      #12;
      check("rst_valid", 32'(o_last_valid), 32'd0);
      check("rst_last", 32'(o_last), 32'd0);
      check("rst_out", 32'(o_outstanding), 32'd0);
      check("rst_spur", 32'(o_err_spurious), 32'd0);
      check("rst_orph", 32'(o_err_orphan), 32'd0);
      check("rst_ready", 32'(i_addr_ready), 32'd1);
      check("rst_stat", 32'(o_stat_pkts), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Single packet
      do_beat(12'h000);
      check("p1_out_b0", 32'(o_outstanding), 32'd1);
      check("p1_novalid", 32'(o_last_valid), 32'd0);
      do_beat(12'h004);
      check_verdict("p1_v0", 1'b0);
      do_beat(12'h008);
      check_verdict("p1_v1", 1'b0);
      do_beat(12'h00C);
      check_verdict("p1_v2", 1'b0);
      tick();
      check("p1_drained", 32'(o_last_valid), 32'd0);
      tick();
      tick();
      do_complete();
      check_verdict("p1_tie", 1'b1);
      check("p1_out_end", 32'(o_outstanding), 32'd0);
      tick();
      check("p1_empty", 32'(o_last_valid), 32'd0);
`ifdef LASTBEAT_STATS_EN
      check("p1_stat", 32'(o_stat_pkts), 32'd1);
`else
      check("p1_stat", 32'(o_stat_pkts), 32'd0);
`endif

      // Back-to-back packets
      do_beat(12'h000);
      do_beat(12'h004);
      check_verdict("bb_v0", 1'b0);
      do_beat(12'h008);
      check_verdict("bb_v1", 1'b0);
      do_beat(12'h00C);
      check_verdict("bb_v2", 1'b0);
      do_beat(12'h000);
      check_verdict("bb_wrap", 1'b1);
      check("bb_out2", 32'(o_outstanding), 32'd2);
      do_beat(12'h004);
      check_verdict("bb_v4", 1'b0);
      check("bb_out2b", 32'(o_outstanding), 32'd2);
      do_complete();
      check("bb_late_nopush", 32'(o_last_valid), 32'd0);
      check("bb_out1", 32'(o_outstanding), 32'd1);
      tick();
      do_complete();
      check_verdict("bb_tie", 1'b1);
      check("bb_out0", 32'(o_outstanding), 32'd0);
      tick();

      // Simultaneous tie-off and wrap beat into buffer 1
      do_beat(12'h000);
      check("sim_out1", 32'(o_outstanding), 32'd1);
      i_dma_complete = 1'b1;
      do_beat(12'h800);
      i_dma_complete = 1'b0;
      check_verdict("sim_tie", 1'b1);
      check("sim_out_keep", 32'(o_outstanding), 32'd1);
      do_beat(12'h804);
      check_verdict("sim_next", 1'b0);
      tick();
      check("sim_single", 32'(o_last_valid), 32'd0);
      do_complete();
      check("sim_out0", 32'(o_outstanding), 32'd0);
      tick();

      // Backpressure
      o_last_ready = 1'b0;
      do_beat(12'h000);
      do_beat(12'h004);
      check("bp_ready1", 32'(i_addr_ready), 32'd1);
      do_beat(12'h008);
      check("bp_ready2", 32'(i_addr_ready), 32'd1);
      do_beat(12'h00C);
      check("bp_ready3", 32'(i_addr_ready), 32'd0);
      i_addr_valid = 1'b1;
      i_addr_data  = 12'h010;
      tick();
      i_addr_valid = 1'b0;
      check_verdict("bp_hold", 1'b0);
      check("bp_out_held", 32'(o_outstanding), 32'd1);
      do_complete();
      check_verdict("bp_full_hold", 1'b0);
      check("bp_out0", 32'(o_outstanding), 32'd0);
      check("bp_ready_full", 32'(i_addr_ready), 32'd0);
      o_last_ready = 1'b1;
      tick();
      check_verdict("bp_d1", 1'b0);
      tick();
      check_verdict("bp_d2", 1'b0);
      tick();
      check_verdict("bp_d3", 1'b1);
      tick();
      check("bp_empty", 32'(o_last_valid), 32'd0);
      check("bp_ready_back", 32'(i_addr_ready), 32'd1);

      // Outstanding limit
      do_beat(12'h000);
      do_beat(12'h000);
      do_beat(12'h000);
      do_beat(12'h000);
      check("lim_out4", 32'(o_outstanding), 32'd4);
      check("lim_ready0", 32'(i_addr_ready), 32'd0);
      i_addr_valid = 1'b1;
      i_addr_data  = 12'h000;
      tick();
      check("lim_blocked", 32'(o_outstanding), 32'd4);
      i_dma_complete = 1'b1;
      tick();
      i_dma_complete = 1'b0;
      check("lim_out3", 32'(o_outstanding), 32'd3);
      check("lim_ready1", 32'(i_addr_ready), 32'd1);
      tick();
      i_addr_valid = 1'b0;
      check("lim_fifth", 32'(o_outstanding), 32'd4);
      check_verdict("lim_v5", 1'b1);
      do_complete();
      do_complete();
      do_complete();
      check("lim_out1", 32'(o_outstanding), 32'd1);
      do_complete();
      check_verdict("lim_tie", 1'b1);
      check("lim_out0", 32'(o_outstanding), 32'd0);
      tick();

      // Spurious and orphan events
      do_complete();
      check("err_spur", 32'(o_err_spurious), 32'd1);
      check("err_spur_nopush", 32'(o_last_valid), 32'd0);
      tick();
      check("err_spur_pulse", 32'(o_err_spurious), 32'd0);
      do_beat(12'h010);
      check("err_orph", 32'(o_err_orphan), 32'd1);
      check("err_orph_out", 32'(o_outstanding), 32'd0);
      tick();
      check("err_orph_pulse", 32'(o_err_orphan), 32'd0);
`ifdef LASTBEAT_STATS_EN
      check("stat_pkts", 32'(o_stat_pkts), 32'd11);
      check("stat_spur", 32'(o_stat_spurious), 32'd1);
`else
      check("stat_pkts", 32'(o_stat_pkts), 32'd0);
      check("stat_spur", 32'(o_stat_spurious), 32'd0);
`endif

      // Asynchronous reset mid-packet
      o_last_ready = 1'b0;
      do_beat(12'h000);
      do_beat(12'h004);
      check_verdict("ar_pre", 1'b0);
      check("ar_pre_out", 32'(o_outstanding), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_valid", 32'(o_last_valid), 32'd0);
      check("ar_out", 32'(o_outstanding), 32'd0);
      check("ar_stat", 32'(o_stat_pkts), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("ar_post_valid", 32'(o_last_valid), 32'd0);
      check("ar_post_ready", 32'(i_addr_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
